// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A phase divider produces a pixel tick; x/y raster counters, sync/valid
// flags and line/frame strobes are all registered so that every output
// describes the same pixel in any given cycle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned HSYNC_POL = 0,
  parameter int unsigned VSYNC_POL = 0,
  parameter int unsigned CW        = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          valid_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          pixclk_o,
  output logic          newline_o,
  output logic          newframe_o,
  output logic [7:0]    frame_cnt_o
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = VS_START + V_SYNC;
  localparam int unsigned PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned XW        = CW + 1;
  localparam logic        HS_ON     = 1'(HSYNC_POL);
  localparam logic        VS_ON     = 1'(VSYNC_POL);

  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          valid_q, valid_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          pix_q, pix_d;
  logic          nl_q, nl_d;
  logic          nf_q, nf_d;
  logic          tick_c;

  // Next-state: divider phase, raster counters, strobes and flags derived from next x/y
  always_comb begin
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    fcnt_d  = fcnt_q;
    pix_d   = 1'b0;
    nl_d    = 1'b0;
    nf_d    = 1'b0;
    tick_c  = en_i && (phase_q == PW'(CLK_DIV - 1));

    if (en_i) begin
      phase_d = tick_c ? '0 : phase_q + PW'(1);
    end

    if (tick_c) begin
      pix_d = 1'b1;
      if (x_q == CW'(H_TOTAL - 1)) begin
        x_d  = '0;
        nl_d = 1'b1;
        if (y_q == CW'(V_TOTAL - 1)) begin
          y_d    = '0;
          nf_d   = 1'b1;
          fcnt_d = fcnt_q + 8'd1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end

    // Widened compares keep region bounds equal to the totals representable
    valid_d = (XW'(x_d) < XW'(H_ACTIVE)) && (XW'(y_d) < XW'(V_ACTIVE));
    hsync_d = ((XW'(x_d) >= XW'(HS_START)) && (XW'(x_d) < XW'(HS_END))) ? HS_ON : ~HS_ON;
    vsync_d = ((XW'(y_d) >= XW'(VS_START)) && (XW'(y_d) < XW'(VS_END))) ? VS_ON : ~VS_ON;
  end

  // State and output registers; reset presents pixel (0,0) with all strobes high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fcnt_q  <= '0;
      valid_q <= 1'b1;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      pix_q   <= 1'b1;
      nl_q    <= 1'b1;
      nf_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fcnt_q  <= fcnt_d;
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      pix_q   <= pix_d;
      nl_q    <= nl_d;
      nf_q    <= nf_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign valid_o     = valid_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign pixclk_o    = pix_q;
  assign newline_o   = nl_q;
  assign newframe_o  = nf_q;
  assign frame_cnt_o = fcnt_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: divides the system clock down to a pixel rate and produces pixel coordinates, sync pulses, an active-video flag and line/frame strobes for the video pipeline. All timing (active/porch/sync widths, clock divide ratio, sync polarity) is set by parameters, so 640x480@60 and other modes come from one block. Adds a pause enable, a frame counter and registered sync/valid outputs aligned with the coordinates. Sits between the clock and the framebuffer readout / pixel shader logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- HSYNC_POL, 0, level of hsync while in sync region (0 = active-low)
- VSYNC_POL, 0, level of vsync while in sync region
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  1 = run, 0 = freeze divider and counters
- x  output  CW  current column, 0..H_TOTAL-1
- y  output  CW  current line, 0..V_TOTAL-1
- valid  output  1  x<H_ACTIVE and y<V_ACTIVE
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- pixclk  output  1  one-clk strobe on each pixel advance
- newline  output  1  one-clk strobe when x wraps to 0
- newframe  output  1  one-clk strobe when x and y wrap to 0
- frame_cnt  output  8  frames completed, wraps 255->0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Divider phase counter 0..CLK_DIV-1. Pixel tick when en=1 and phase==CLK_DIV-1; phase then returns to 0. CLK_DIV=1: tick every en=1 cycle.
- On tick: x<H_TOTAL-1 -> x+1; else x=0, newline, and y<V_TOTAL-1 -> y+1, else y=0, newframe, frame_cnt+1.
- hsync in sync region when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751); vsync region V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491). In region output = *_POL, else ~*_POL.
- valid, hsync, vsync are registered, computed from next x/y, so in every cycle they exactly match the x/y visible that cycle.
- en=0: phase, x, y, frame_cnt, valid, syncs hold; pixclk/newline/newframe = 0.
- Strobes default 0 every cycle unless set by a tick or reset.

## Timing
- Reset (any edge with rst=1, overrides en): x=0, y=0, phase=0, frame_cnt=0, valid=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, pixclk=newline=newframe=1.
- First edge after rst falls with en=1: strobes 0; first tick on the CLK_DIV-th edge after release (x=1, pixclk=1 that cycle).
- Latency tick -> outputs: 1 clk (registered); strobes coincide with the new x/y values.
- Pixel period CLK_DIV clks; line H_TOTAL*CLK_DIV clks; frame H_TOTAL*V_TOTAL*CLK_DIV clks (default 840000).
- newline and newframe assert in the same cycle at frame wrap; pixclk also 1 then.
- Reset mid-line/mid-frame: restart at reset state next cycle, no partial strobes.
- en deasserted on tick-pending cycle: no tick; resumes from same phase when en=1.

## Test plan
- Reset held 3 clks, release, en=1 -> x=0,y=0,strobes 1 during reset, 0 on first post-reset cycle; x=1 with pixclk after 2nd edge; pixclk period 2 clks.
- Run defaults one line -> hsync low exactly for x=656..751 (192 clks), valid=0 for x>=640; x 799->0 with newline=1 one clk, y=1.
- Run full frame -> vsync low exactly y=490..491, y 524->0 with newline=newframe=1 same clk, frame_cnt 0->1; frame length 840000 clks; force 256 frames (or preload) -> frame_cnt wraps 255->0.
- Toggle en=0 for 7 clks mid-line at x=100 -> x, y, phase frozen, no strobes; resumes x=101 after remaining phase.
- Assert rst at x=700,y=300 for 1 clk -> next cycle x=0,y=0,hsync/vsync inactive, frame_cnt=0, strobes 1.
- Instance CLK_DIV=1, 800x600@60 (H 800/40/128/88, V 600/1/4/23), HSYNC_POL=VSYNC_POL=1 -> tick every clk, hsync high x=840..967, vsync high y=601..604, H_TOTAL 1056, V_TOTAL 628 (CW=11).
